// File: rtl/arb_pkg.sv
// Shared sizes and state encoding for the round-robin grant arbiter.
package arb_pkg;
  localparam int NUM_REQ = 32;
  localparam int ID_W    = 5;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_e;
endpackage

// File: rtl/priority_encoder.sv
// LSB-first priority encoder: idx is the lowest set bit of in_vec.
// idx is x when in_vec is zero, so callers must qualify it with found.
module priority_encoder #(
  parameter int W     = 32,
  parameter int IDX_W = $clog2(W)
) (
  input  logic [W-1:0]     in_vec,
  output logic [IDX_W-1:0] idx,
  output logic             found
);
  always_comb begin
    idx = 'x;
    for (int i = W-1; i >= 0; i--)
      if (in_vec[i]) idx = IDX_W'(i);
  end

  assign found = |in_vec;
endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter over 32 requesters: registered one-hot grant held until
// release, abandon, or the MAX_HOLD limit, with no bubble between grants.
module rr_grant_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               release_i,
  output logic               gnt_valid_o,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    gnt_id_o,
  output logic               timeout_o
);
  localparam int HC_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [HC_W-1:0] HOLD_SAT  = '1;

  arb_state_e         state;
  logic [ID_W-1:0]    gnt_id_q;
  logic [ID_W-1:0]    last_q;
  logic [HC_W-1:0]    hold_cnt;

  logic [NUM_REQ-1:0] above_mask;
  logic [1:0][NUM_REQ-1:0] enc_in;
  logic [1:0][ID_W-1:0]    enc_idx;
  logic [1:0]              enc_found;
  logic [ID_W-1:0]    winner;
  logic               any_req;
  logic               abandon;
  logic               hold_limit;
  logic               end_grant;

  // With last_q = 31 the shift overflows to zero, so the mask is empty.
  assign above_mask = ~((NUM_REQ'(2) << last_q) - NUM_REQ'(1));
  assign enc_in[0]  = req_i & above_mask;
  assign enc_in[1]  = req_i;

  for (genvar g = 0; g < 2; g++) begin : g_enc
    priority_encoder #(.W(NUM_REQ), .IDX_W(ID_W)) u_enc (
      .in_vec (enc_in[g]),
      .idx    (enc_idx[g]),
      .found  (enc_found[g])
    );
  end

  // Encoder outputs only pass through when their input is non-zero.
  assign any_req = enc_found[1];
  assign winner  = enc_found[0] ? enc_idx[0] :
                   enc_found[1] ? enc_idx[1] : '0;

  assign abandon    = !req_i[gnt_id_q];
  assign hold_limit = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
  assign end_grant  = release_i || abandon || hold_limit;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state    <= ARB_IDLE;
      gnt_id_q <= '0;
      last_q   <= ID_W'(NUM_REQ - 1);
      hold_cnt <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (any_req) begin
            state    <= ARB_GRANT;
            gnt_id_q <= winner;
            last_q   <= winner;
            hold_cnt <= '0;
          end
        end
        ARB_GRANT: begin
          if (end_grant) begin
            hold_cnt <= '0;
            if (any_req) begin
              gnt_id_q <= winner;
              last_q   <= winner;
            end else begin
              state    <= ARB_IDLE;
              gnt_id_q <= '0;
            end
          end else if (hold_cnt != HOLD_SAT) begin
            hold_cnt <= hold_cnt + HC_W'(1);
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign gnt_valid_o = (state == ARB_GRANT);
  assign gnt_id_o    = gnt_id_q;
  // Release and abandon both beat the limit, so the pulse marks pure timeouts.
  assign timeout_o   = gnt_valid_o && hold_limit && !release_i && !abandon;

  always_comb begin
    gnt_o = '0;
    if (gnt_valid_o) gnt_o[gnt_id_q] = 1'b1;
  end
endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench: each table row gives the inputs for one cycle and the
// outputs expected during that cycle, before the next clock edge.
module tb_rr_grant_arbiter;
  logic        clk = 1'b0;
  logic        reset_i;
  logic [31:0] req_i;
  logic        release_i;
  logic        gnt_valid_o;
  logic [31:0] gnt_o;
  logic [4:0]  gnt_id_o;
  logic        timeout_o;

  int checks = 0;
  int errors = 0;

  rr_grant_arbiter #(.MAX_HOLD(4)) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .req_i       (req_i),
    .release_i   (release_i),
    .gnt_valid_o (gnt_valid_o),
    .gnt_o       (gnt_o),
    .gnt_id_o    (gnt_id_o),
    .timeout_o   (timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] req;
    logic        rel;
    logic        v;
    logic [4:0]  id;
    logic        to;
  } vec_t;

  localparam int NV = 45;
  vec_t tbl [NV];

  function automatic vec_t mk(logic rst, logic [31:0] req, logic rel,
                              logic v, logic [4:0] id, logic to);
    vec_t r;
    r.rst = rst; r.req = req; r.rel = rel; r.v = v; r.id = id; r.to = to;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_outs(string tag, logic v, logic [4:0] id, logic to);
    logic [31:0] exp_gnt;
    exp_gnt = v ? (32'd1 << id) : 32'd0;
    chk({tag, ".valid"},   {31'd0, gnt_valid_o}, {31'd0, v});
    chk({tag, ".id"},      {27'd0, gnt_id_o},    {27'd0, id});
    chk({tag, ".gnt"},     gnt_o,                exp_gnt);
    chk({tag, ".timeout"}, {31'd0, timeout_o},   {31'd0, to});
  endtask

  initial begin
    // basic grant, release handoff and wrap
    tbl[0]  = mk(0, 32'h0,        0, 0, 0,  0);
    tbl[1]  = mk(0, 32'h5,        0, 0, 0,  0);
    tbl[2]  = mk(0, 32'h5,        1, 1, 0,  0);
    tbl[3]  = mk(0, 32'h5,        1, 1, 2,  0);
    tbl[4]  = mk(0, 32'h5,        0, 1, 0,  0);
    tbl[5]  = mk(0, 32'h0,        0, 1, 0,  0);
    tbl[6]  = mk(0, 32'h0,        0, 0, 0,  0);
    // release while idle is ignored
    tbl[7]  = mk(0, 32'h0,        1, 0, 0,  0);
    tbl[8]  = mk(0, 32'h0,        0, 0, 0,  0);
    // hold limit alternation between bits 1 and 4
    tbl[9]  = mk(0, 32'h12,       0, 0, 0,  0);
    tbl[10] = mk(0, 32'h12,       0, 1, 1,  0);
    tbl[11] = mk(0, 32'h12,       0, 1, 1,  0);
    tbl[12] = mk(0, 32'h12,       0, 1, 1,  0);
    tbl[13] = mk(0, 32'h12,       0, 1, 1,  1);
    tbl[14] = mk(0, 32'h12,       0, 1, 4,  0);
    tbl[15] = mk(0, 32'h12,       0, 1, 4,  0);
    tbl[16] = mk(0, 32'h12,       0, 1, 4,  0);
    tbl[17] = mk(0, 32'h12,       0, 1, 4,  1);
    tbl[18] = mk(0, 32'h12,       0, 1, 1,  0);
    tbl[19] = mk(0, 32'h0,        0, 1, 1,  0);
    tbl[20] = mk(0, 32'h0,        0, 0, 0,  0);
    // sole requester 7: timeout then immediate re-grant with fresh count
    tbl[21] = mk(0, 32'h80,       0, 0, 0,  0);
    tbl[22] = mk(0, 32'h80,       0, 1, 7,  0);
    tbl[23] = mk(0, 32'h80,       0, 1, 7,  0);
    tbl[24] = mk(0, 32'h80,       0, 1, 7,  0);
    tbl[25] = mk(0, 32'h80,       0, 1, 7,  1);
    tbl[26] = mk(0, 32'h80,       0, 1, 7,  0);
    tbl[27] = mk(0, 32'h80,       0, 1, 7,  0);
    tbl[28] = mk(0, 32'h80,       0, 1, 7,  0);
    tbl[29] = mk(0, 32'h80,       1, 1, 7,  0);
    tbl[30] = mk(0, 32'h0,        0, 1, 7,  0);
    tbl[31] = mk(0, 32'h0,        0, 0, 0,  0);
    // owner 3 abandons while 9 pends
    tbl[32] = mk(0, 32'h8,        0, 0, 0,  0);
    tbl[33] = mk(0, 32'h208,      0, 1, 3,  0);
    tbl[34] = mk(0, 32'h200,      0, 1, 3,  0);
    tbl[35] = mk(0, 32'h200,      0, 1, 9,  0);
    tbl[36] = mk(0, 32'h0,        0, 1, 9,  0);
    tbl[37] = mk(0, 32'h0,        0, 0, 0,  0);
    // reset mid-grant on 20, pointer returns to 31
    tbl[38] = mk(0, 32'h0010_0000, 0, 0, 0,  0);
    tbl[39] = mk(0, 32'h0010_0000, 0, 1, 20, 0);
    tbl[40] = mk(1, 32'h0010_0001, 0, 1, 20, 0);
    tbl[41] = mk(0, 32'h0010_0001, 0, 0, 0,  0);
    tbl[42] = mk(0, 32'h0010_0001, 1, 1, 0,  0);
    tbl[43] = mk(0, 32'h0,        0, 1, 20, 0);
    tbl[44] = mk(0, 32'h0,        0, 0, 0,  0);

    reset_i = 1'b1; req_i = '0; release_i = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < NV; i++) begin
      #2;
      reset_i   = tbl[i].rst;
      req_i     = tbl[i].req;
      release_i = tbl[i].rel;
      #1;
      chk_outs($sformatf("vec%0d", i), tbl[i].v, tbl[i].id, tbl[i].to);
      @(posedge clk);
    end

    // all requesters with release every cycle: full sweep with no bubble
    #2; reset_i = 1'b1; req_i = '0; release_i = 1'b0;
    @(posedge clk);
    #2; reset_i = 1'b0; req_i = 32'hFFFF_FFFF; release_i = 1'b1;
    #1; chk_outs("sweep_pre", 1'b0, 5'd0, 1'b0);
    @(posedge clk);
    for (int i = 0; i < 33; i++) begin
      #3;
      chk_outs($sformatf("sweep%0d", i), 1'b1, 5'(i % 32), 1'b0);
      @(posedge clk);
    end
    #2; req_i = '0; release_i = 1'b0;
    @(posedge clk);
    #3; chk_outs("sweep_end", 1'b0, 5'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
